// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Round-robin arbiter sharing one AXI-read-to-APB bridge among NUM_M AXI
//   read masters. One master owns the bridge for a whole burst; its AR fields
//   are latched and presented to the bridge, and R beats are steered back to it.
//   Beat count is checked against arlen, and a watchdog aborts stalled bursts.
// Ports
//   clk, res              clock, synchronous active-high reset
//   m_ar*/m_arready       per-master address channel (fields packed per master)
//   m_r*                  per-master data channel; m_rdata/m_rresp broadcast
//   s_ar*/s_r*            bridge-side AR/R channel
//   gnt_id, busy          current owner (valid while busy) and activity flag
//   err_len, err_tmo      1-cycle error pulses (beat-count mismatch, watchdog)
module axi_rd_arbiter #(
  parameter int NUM_M   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [NUM_M-1:0]     m_arvalid,
  input  logic [2*NUM_M-1:0]   m_arburst,
  input  logic [4*NUM_M-1:0]   m_arlen,
  input  logic [5*NUM_M-1:0]   m_araddr,
  output logic [NUM_M-1:0]     m_arready,
  input  logic [NUM_M-1:0]     m_rready,
  output logic [NUM_M-1:0]     m_rvalid,
  output logic [NUM_M-1:0]     m_rlast,
  output logic [15:0]          m_rdata,
  output logic                 m_rresp,
  output logic                 s_arvalid,
  output logic [1:0]           s_arburst,
  output logic [3:0]           s_arlen,
  output logic [4:0]           s_araddr,
  input  logic                 s_arready,
  input  logic                 s_rvalid,
  input  logic [15:0]          s_rdata,
  input  logic                 s_rresp,
  input  logic                 s_rlast,
  output logic                 s_rready,
  output logic [2:0]           gnt_id,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_tmo
);
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [1:0]       arburst_q, arburst_d;
  logic [3:0]       arlen_q, arlen_d;
  logic [4:0]       araddr_q, araddr_d;

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  logic             found;
  logic [IDX_W-1:0] pick;
  int               idx;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_M; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_M;
      if (!found && m_arvalid[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  logic in_data, beat;
  assign in_data = (state_q == DATA);
  assign beat    = in_data & s_rvalid & m_rready[gnt_q];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    wdog_d    = wdog_q;
    arburst_d = arburst_q;
    arlen_d   = arlen_q;
    araddr_d  = araddr_q;
    err_len   = 1'b0;
    err_tmo   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        gnt_d     = pick;
        arburst_d = m_arburst[2*int'(pick) +: 2];
        arlen_d   = m_arlen[4*int'(pick) +: 4];
        araddr_d  = m_araddr[5*int'(pick) +: 5];
        cnt_d     = {1'b0, m_arlen[4*int'(pick) +: 4]} + 5'd1;
        rr_ptr_d  = (pick == IDX_W'(NUM_M - 1)) ? '0 : pick + IDX_W'(1);
        state_d   = ADDR;
      end
      ADDR: if (s_arready) begin
        wdog_d  = '0;
        state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          cnt_d  = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
          wdog_d = '0;
          if (s_rlast) begin
            err_len = (cnt_q != 5'd1);
            state_d = IDLE;
          end else if (cnt_q == 5'd1) begin
            // Bridge overran arlen: flag it but keep forwarding until rlast.
            err_len = 1'b1;
          end
        end else begin
          wdog_d = wdog_q + WD_W'(1);
          // Pulse in the cycle the counter reaches TIMEOUT; owner released next.
          if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            err_tmo = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      wdog_q    <= '0;
      arburst_q <= '0;
      arlen_q   <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      wdog_q    <= wdog_d;
      arburst_q <= arburst_d;
      arlen_q   <= arlen_d;
      araddr_q  <= araddr_d;
    end
  end

  assign s_arvalid = (state_q == ADDR);
  assign s_arburst = arburst_q;
  assign s_arlen   = arlen_q;
  assign s_araddr  = araddr_q;
  assign s_rready  = in_data & m_rready[gnt_q];
  assign busy      = (state_q != IDLE);
  assign gnt_id    = 3'(gnt_q);
  // Broadcast data is gated outside DATA so idle/reset outputs read as 0.
  assign m_rdata   = in_data ? s_rdata : 16'h0;
  assign m_rresp   = in_data & s_rresp;

  for (genvar k = 0; k < NUM_M; k++) begin : g_m
    logic own;
    assign own          = (gnt_q == IDX_W'(k));
    assign m_arready[k] = (state_q == ADDR) & own & s_arready;
    assign m_rvalid[k]  = in_data & own & s_rvalid;
    assign m_rlast[k]   = in_data & own & s_rlast;
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  localparam int NUM_M   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              res;
  logic [NUM_M-1:0]  m_arvalid;
  logic [2*NUM_M-1:0] m_arburst;
  logic [4*NUM_M-1:0] m_arlen;
  logic [5*NUM_M-1:0] m_araddr;
  logic [NUM_M-1:0]  m_arready, m_rready, m_rvalid, m_rlast;
  logic [15:0]       m_rdata;
  logic              m_rresp;
  logic              s_arvalid;
  logic [1:0]        s_arburst;
  logic [3:0]        s_arlen;
  logic [4:0]        s_araddr;
  logic              s_arready, s_rvalid, s_rresp, s_rlast, s_rready;
  logic [15:0]       s_rdata;
  logic [2:0]        gnt_id;
  logic              busy, err_len, err_tmo;

  int checks = 0;
  int failures = 0;
  int len_cfg = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .res(res),
    .m_arvalid(m_arvalid), .m_arburst(m_arburst), .m_arlen(m_arlen), .m_araddr(m_araddr),
    .m_arready(m_arready), .m_rready(m_rready), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_arvalid(s_arvalid), .s_arburst(s_arburst), .s_arlen(s_arlen), .s_araddr(s_araddr),
    .s_arready(s_arready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rready(s_rready),
    .gnt_id(gnt_id), .busy(busy), .err_len(err_len), .err_tmo(err_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res = 1'b1;
    tick();
    tick();
    res = 1'b0;
  endtask

  // Master k: burst=k, addr=k+4, len=len_cfg.
  task automatic set_cfg(input int len);
    len_cfg = len;
    for (int k = 0; k < NUM_M; k++) begin
      m_arburst[2*k +: 2] = 2'(k);
      m_arlen[4*k +: 4]   = 4'(len);
      m_araddr[5*k +: 5]  = 5'(k + 4);
    end
  endtask

  // Entered from IDLE with requests already driven; runs a clean burst.
  task automatic run_burst(input int g, input int nb);
    logic [15:0] d;
    tick();
    chk("grant_busy", busy, 1);
    chk("gnt_id", gnt_id, g);
    chk("s_arvalid", s_arvalid, 1);
    chk("s_araddr", s_araddr, g + 4);
    chk("s_arburst", s_arburst, g % 4);
    chk("s_arlen", s_arlen, len_cfg);
    s_arready = 1'b1;
    #1;
    chk("m_arready", m_arready, 1 << g);
    tick();
    s_arready = 1'b0;
    for (int b = 0; b < nb; b++) begin
      d = 16'($urandom);
      s_rvalid = 1'b1;
      s_rlast  = (b == nb - 1);
      s_rdata  = d;
      #1;
      chk("m_rvalid", m_rvalid, 1 << g);
      chk("m_rdata", m_rdata, d);
      chk("m_rlast", m_rlast, (b == nb - 1) ? (1 << g) : 0);
      chk("err_len_clean", err_len, 0);
      tick();
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    #1;
    chk("idle_after_burst", busy, 0);
  endtask

  initial begin
    res = 1'b1; m_arvalid = '0; m_arburst = '0; m_arlen = '0; m_araddr = '0;
    m_rready = '1; s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 0; s_rlast = 0;
    do_reset();
    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_err", {err_len, err_tmo}, 0);

    // 1: single-beat burst from master 0
    m_arvalid = 4'b0001; m_arlen[3:0] = 4'd0; m_araddr[4:0] = 5'h03; m_arburst[1:0] = 2'd1;
    #1;
    chk("t1_idle", busy, 0);
    tick();
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_araddr", s_araddr, 5'h03);
    chk("t1_s_arburst", s_arburst, 1);
    s_arready = 1'b1;
    #1;
    chk("t1_m_arready", m_arready, 4'b0001);
    tick();
    s_arready = 1'b0; m_arvalid = '0;
    s_rvalid = 1; s_rlast = 1; s_rdata = 16'hA5A5; s_rresp = 1;
    #1;
    chk("t1_m_rvalid", m_rvalid, 4'b0001);
    chk("t1_m_rdata", m_rdata, 16'hA5A5);
    chk("t1_m_rresp", m_rresp, 1);
    chk("t1_s_rready", s_rready, 1);
    chk("t1_err_len", err_len, 0);
    tick();
    s_rvalid = 0; s_rlast = 0; s_rresp = 0;
    #1;
    chk("t1_back_idle", busy, 0);
    chk("t1_err", {err_len, err_tmo}, 0);

    // 2: masters 1 and 3 requesting, rr_ptr=0 after reset
    do_reset();
    set_cfg(3);
    m_arvalid = 4'b1010;
    run_burst(1, 4);
    run_burst(3, 4);
    m_arvalid = '0;

    // 3: all four requesting -> 0,1,2,3,0,1,2,3
    do_reset();
    set_cfg(0);
    m_arvalid = 4'b1111;
    for (int n = 0; n < 8; n++) run_burst(n % 4, 1);
    m_arvalid = '0;

    // 4a: arlen=3, rlast early on beat 2
    do_reset();
    set_cfg(3);
    m_arvalid = 4'b0100;
    tick();
    chk("t4_gnt", gnt_id, 2);
    m_arvalid = '0;
    s_arready = 1; tick(); s_arready = 0;
    s_rvalid = 1; s_rlast = 0;
    #1; chk("t4a_beat1_err", err_len, 0);
    tick();
    s_rlast = 1;
    #1; chk("t4a_beat2_err", err_len, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t4a_idle", busy, 0);
    chk("t4a_err_clear", err_len, 0);

    // 4b: no rlast on beat 4; exits on beat 5 rlast (cnt saturated at 0)
    m_arvalid = 4'b0100;
    tick();
    m_arvalid = '0;
    s_arready = 1; tick(); s_arready = 0;
    s_rvalid = 1; s_rlast = 0;
    for (int b = 1; b <= 3; b++) begin
      #1; chk("t4b_beat_err", err_len, 0);
      tick();
    end
    #1; chk("t4b_beat4_err", err_len, 1);
    tick();
    chk("t4b_still_busy", busy, 1);
    chk("t4b_err_single", err_len, 0);
    s_rlast = 1;
    #1;
    chk("t4b_late_m_rlast", m_rlast, 4'b0100);
    chk("t4b_late_err", err_len, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1; chk("t4b_idle", busy, 0);

    // 5: watchdog with TIMEOUT=15
    m_arvalid = 4'b0001;
    tick();
    m_arvalid = '0;
    s_arready = 1; tick(); s_arready = 0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      #1;
      chk("t5_err_tmo", err_tmo, (c == TIMEOUT) ? 1 : 0);
      chk("t5_busy", busy, 1);
      tick();
    end
    chk("t5_idle_after_tmo", busy, 0);
    chk("t5_tmo_clear", err_tmo, 0);

    // 6: reset mid-burst (owner master 1 leaves rr_ptr=2)
    do_reset();
    set_cfg(1);
    m_arvalid = 4'b0010;
    tick();
    m_arvalid = '0;
    s_arready = 1; tick(); s_arready = 0;
    s_rvalid = 1; s_rdata = 16'h1234;
    #1; chk("t6_pre_m_rvalid", m_rvalid, 4'b0010);
    res = 1;
    tick();
    chk("t6_busy", busy, 0);
    chk("t6_s_arvalid", s_arvalid, 0);
    chk("t6_s_ar", {s_arburst, s_arlen, s_araddr}, 0);
    chk("t6_gnt_id", gnt_id, 0);
    chk("t6_m_rvalid", m_rvalid, 0);
    chk("t6_m_rdata", m_rdata, 0);
    chk("t6_s_rready", s_rready, 0);
    res = 0; s_rvalid = 0; s_rdata = '0;
    m_arvalid = 4'b0110;
    run_burst(1, 2);
    m_arvalid = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
